// File: rtl/rtc_7seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_7seg_scan
//  Brief    : HH:MM[:SS] RTC with button set modes, 12/24 h formatting and a
//             multiplexed 7-segment scan driver. Optional alarm: RTC_ALARM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_7seg_scan #(
  parameter int CLK_HZ     = 10_000_000,
  parameter int SCAN_DIV   = 5000,
  parameter int NUM_DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  prog,
  input  logic                  adjust,
  input  logic                  fmt12,
  input  logic                  com_anode,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  ampm,
  output logic                  sec_tick,
  output logic                  alarm
);
  localparam int c_PRE_W  = $clog2(CLK_HZ);
  localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_PRE_W-1:0]    c_PRE_MAX  = c_PRE_W'(CLK_HZ - 1);
  localparam logic [c_SCAN_W-1:0]   c_SCAN_MAX = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [2:0]            c_LAST_IDX = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_DIG0     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  localparam logic [2:0] c_RUN     = 3'd0;
  localparam logic [2:0] c_SET_SEC = 3'd1;
  localparam logic [2:0] c_SET_MIN = 3'd2;
  localparam logic [2:0] c_SET_HR  = 3'd3;
`ifdef RTC_ALARM_EN
  localparam logic [2:0] c_AL_MIN  = 3'd4;
  localparam logic [2:0] c_AL_HR   = 3'd5;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;  4'd1: seg7 = 7'h06;  4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;  4'd4: seg7 = 7'h66;  4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;  4'd7: seg7 = 7'h07;  4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;  default: seg7 = 7'h00;
    endcase
  endfunction

  // Button conditioning: 2-FF synchroniser, third flop for edge, registered pulse
  logic [2:0] r_prog_sync, r_adj_sync;
  logic       r_prog_p, r_adj_p;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prog_sync <= 3'b000;
      r_adj_sync  <= 3'b000;
      r_prog_p    <= 1'b0;
      r_adj_p     <= 1'b0;
    end else begin
      r_prog_sync <= {r_prog_sync[1:0], prog};
      r_adj_sync  <= {r_adj_sync[1:0], adjust};
      r_prog_p    <= r_prog_sync[1] & ~r_prog_sync[2];
      r_adj_p     <= r_adj_sync[1] & ~r_adj_sync[2];
    end
  end

  logic w_adj_only;
  assign w_adj_only = r_adj_p & ~r_prog_p;

  // Mode FSM
  logic [2:0] r_mode, w_mode_nxt;
  logic       w_run, w_sel_sec, w_sel_min, w_sel_hr, w_adj_time;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode <= c_RUN;
    else        r_mode <= w_mode_nxt;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (r_prog_p) begin
      case (r_mode)
        c_RUN:     w_mode_nxt = (NUM_DIGITS == 4) ? c_SET_MIN : c_SET_SEC;
        c_SET_SEC: w_mode_nxt = c_SET_MIN;
        c_SET_MIN: w_mode_nxt = c_SET_HR;
`ifdef RTC_ALARM_EN
        c_SET_HR:  w_mode_nxt = c_AL_MIN;
        c_AL_MIN:  w_mode_nxt = c_AL_HR;
`endif
        default:   w_mode_nxt = c_RUN;
      endcase
    end
  end

`ifdef RTC_ALARM_EN
  logic w_sel_al;
`endif
  always_comb begin
    w_run     = 1'b0;
    w_sel_sec = 1'b0;
    w_sel_min = 1'b0;
    w_sel_hr  = 1'b0;
`ifdef RTC_ALARM_EN
    w_sel_al  = 1'b0;
`endif
    case (r_mode)
      c_SET_SEC: w_sel_sec = 1'b1;
      c_SET_MIN: w_sel_min = 1'b1;
      c_SET_HR:  w_sel_hr  = 1'b1;
`ifdef RTC_ALARM_EN
      c_AL_MIN:  begin w_sel_min = 1'b1; w_sel_al = 1'b1; end
      c_AL_HR:   begin w_sel_hr  = 1'b1; w_sel_al = 1'b1; end
`endif
      default:   w_run = 1'b1;
    endcase
  end

`ifdef RTC_ALARM_EN
  assign w_adj_time = w_adj_only & ~w_sel_al;
`else
  assign w_adj_time = w_adj_only;
`endif

  // Second prescaler, parked at 0 outside RUN so re-entry yields a full second
  logic [c_PRE_W-1:0] r_pre;
  logic               r_sec_tick, w_tc;
  assign w_tc = w_run & ena & (r_pre == c_PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre      <= '0;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_tick <= w_tc;
      if (!w_run)   r_pre <= '0;
      else if (ena) r_pre <= w_tc ? '0 : r_pre + 1'b1;
    end
  end

  // Time registers
  logic [3:0] r_sec_u, r_min_u, w_nmin_u;
  logic [2:0] r_sec_t, r_min_t, w_nmin_t;
  logic [4:0] r_hr, w_nhr;
  logic       w_su_wrap, w_st_wrap, w_mu_wrap, w_mt_wrap, w_hr_wrap, w_min_roll;

  assign w_su_wrap  = (r_sec_u == 4'd9);
  assign w_st_wrap  = (r_sec_t == 3'd5);
  assign w_mu_wrap  = (r_min_u == 4'd9);
  assign w_mt_wrap  = (r_min_t == 3'd5);
  assign w_hr_wrap  = (r_hr == 5'd23);
  assign w_min_roll = w_tc & w_su_wrap & w_st_wrap;
  assign w_nmin_u   = w_mu_wrap ? 4'd0 : r_min_u + 4'd1;
  assign w_nmin_t   = w_mu_wrap ? (w_mt_wrap ? 3'd0 : r_min_t + 3'd1) : r_min_t;
  assign w_nhr      = (w_mu_wrap & w_mt_wrap) ? (w_hr_wrap ? 5'd0 : r_hr + 5'd1) : r_hr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_u <= 4'd0;
      r_sec_t <= 3'd0;
      r_min_u <= 4'd0;
      r_min_t <= 3'd0;
      r_hr    <= 5'd0;
    end else if (w_tc) begin
      r_sec_u <= w_su_wrap ? 4'd0 : r_sec_u + 4'd1;
      if (w_su_wrap) r_sec_t <= w_st_wrap ? 3'd0 : r_sec_t + 3'd1;
      if (w_min_roll) begin
        r_min_u <= w_nmin_u;
        r_min_t <= w_nmin_t;
        r_hr    <= w_nhr;
      end
    end else if (w_adj_time) begin
      // Field edits wrap locally; no carry into the next field
      if (w_sel_sec) begin
        r_sec_u <= w_su_wrap ? 4'd0 : r_sec_u + 4'd1;
        if (w_su_wrap) r_sec_t <= w_st_wrap ? 3'd0 : r_sec_t + 3'd1;
      end
      if (w_sel_min) begin
        r_min_u <= w_nmin_u;
        r_min_t <= w_nmin_t;
      end
      if (w_sel_hr) r_hr <= w_hr_wrap ? 5'd0 : r_hr + 5'd1;
    end
  end

  // Displayed HH:MM source
  logic [3:0] w_dmin_u;
  logic [2:0] w_dmin_t;
  logic [4:0] w_dhr;

`ifdef RTC_ALARM_EN
  logic [3:0] r_al_min_u;
  logic [2:0] r_al_min_t;
  logic [4:0] r_al_hr;
  logic [5:0] r_al_secs;
  logic       r_alarm, w_al_hit;

  assign w_al_hit = w_min_roll & (w_nmin_u == r_al_min_u) & (w_nmin_t == r_al_min_t)
                  & (w_nhr == r_al_hr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_al_min_u <= 4'd0;
      r_al_min_t <= 3'd0;
      r_al_hr    <= 5'd0;
      r_al_secs  <= 6'd0;
      r_alarm    <= 1'b0;
    end else begin
      if (w_adj_only & w_sel_al & w_sel_min) begin
        r_al_min_u <= (r_al_min_u == 4'd9) ? 4'd0 : r_al_min_u + 4'd1;
        if (r_al_min_u == 4'd9) r_al_min_t <= (r_al_min_t == 3'd5) ? 3'd0 : r_al_min_t + 3'd1;
      end
      if (w_adj_only & w_sel_al & w_sel_hr)
        r_al_hr <= (r_al_hr == 5'd23) ? 5'd0 : r_al_hr + 5'd1;
      if (!w_run || r_adj_p || (w_tc && r_al_secs == 6'd59)) begin
        r_alarm   <= 1'b0;
        r_al_secs <= 6'd0;
      end else if (w_al_hit) begin
        r_alarm   <= 1'b1;
        r_al_secs <= 6'd0;
      end else if (r_alarm && w_tc) begin
        r_al_secs <= r_al_secs + 6'd1;
      end
    end
  end

  assign w_dmin_u = w_sel_al ? r_al_min_u : r_min_u;
  assign w_dmin_t = w_sel_al ? r_al_min_t : r_min_t;
  assign w_dhr    = w_sel_al ? r_al_hr    : r_hr;
  assign alarm    = r_alarm;
`else
  assign w_dmin_u = r_min_u;
  assign w_dmin_t = r_min_t;
  assign w_dhr    = r_hr;
  assign alarm    = 1'b0;
`endif

  // 12/24 h formatting and hour split into tens/units
  logic [4:0] w_hr12;
  logic [3:0] w_hr_t, w_hr_u;
  logic       w_pm;
  assign w_pm = fmt12 & (w_dhr >= 5'd12);

  always_comb begin
    w_hr12 = w_dhr;
    if (fmt12) begin
      if (w_dhr == 5'd0)       w_hr12 = 5'd12;
      else if (w_dhr > 5'd12)  w_hr12 = w_dhr - 5'd12;
    end
    w_hr_t = 4'd0;
    w_hr_u = w_hr12[3:0];
    if (w_hr12 >= 5'd20) begin
      w_hr_t = 4'd2;
      w_hr_u = 4'(w_hr12 - 5'd20);
    end else if (w_hr12 >= 5'd10) begin
      w_hr_t = 4'd1;
      w_hr_u = 4'(w_hr12 - 5'd10);
    end
  end

  // Scan: 4-digit builds start at the minute-units position
  logic [c_SCAN_W-1:0] r_scan;
  logic [2:0]          r_idx, w_pos;
  logic [3:0]          w_val;
  logic                w_vis;
  assign w_pos = (NUM_DIGITS == 4) ? r_idx + 3'd2 : r_idx;

  always_comb begin
    w_val = 4'd0;
    w_vis = 1'b0;
    case (w_pos)
      3'd0: begin w_val = r_sec_u;          w_vis = w_run | w_sel_sec; end
      3'd1: begin w_val = {1'b0, r_sec_t};  w_vis = w_run | w_sel_sec; end
      3'd2: begin w_val = w_dmin_u;         w_vis = w_run | w_sel_min; end
      3'd3: begin w_val = {1'b0, w_dmin_t}; w_vis = w_run | w_sel_min; end
      3'd4: begin w_val = w_hr_u;           w_vis = w_run | w_sel_hr;  end
      3'd5: begin w_val = w_hr_t;           w_vis = w_run | w_sel_hr;  end
      default: ;
    endcase
  end

  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_dig;
  logic                  r_ampm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_idx  <= 3'd0;
      r_seg  <= 7'h3F;
      r_dig  <= c_DIG0;
      r_ampm <= 1'b0;
    end else begin
      if (ena) begin
        if (r_scan == c_SCAN_MAX) begin
          r_scan <= '0;
          r_idx  <= (r_idx == c_LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end else begin
          r_scan <= r_scan + 1'b1;
        end
      end
      r_seg  <= w_vis ? seg7(w_val) : 7'h00;
      r_dig  <= c_DIG0 << r_idx;
      r_ampm <= w_pm;
    end
  end

  // Polarity is a board strap, applied after the register
  assign seg_out  = r_seg ^ {7{com_anode}};
  assign dig_en   = r_dig;
  assign ampm     = r_ampm;
  assign sec_tick = r_sec_tick;

endmodule
`default_nettype wire

// File: tb/tb_rtc_7seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_7seg_scan
//  Brief    : Directed self-checking bench for rtc_7seg_scan (20 Hz, 6 digits)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_7seg_scan;
  logic       clk = 1'b0;
  logic       rst_n, ena, prog, adjust, fmt12, com_anode;
  logic [6:0] seg_out;
  logic [5:0] dig_en;
  logic       ampm, sec_tick, alarm;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         got;

  localparam logic [6:0] c_SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  rtc_7seg_scan #(.CLK_HZ(20), .SCAN_DIV(2), .NUM_DIGITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .prog(prog), .adjust(adjust),
    .fmt12(fmt12), .com_anode(com_anode), .seg_out(seg_out), .dig_en(dig_en),
    .ampm(ampm), .sec_tick(sec_tick), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic press(input logic p, input logic a);
    @(negedge clk);
    prog = p;
    adjust = a;
    repeat (4) @(negedge clk);
    prog = 1'b0;
    adjust = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_digit(input string tag, input int k, input logic [6:0] exp);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (dig_en == (6'd1 << k)) begin
        check(tag, {25'd0, seg_out}, {25'd0, exp});
        return;
      end
    end
    check({tag, "_timeout"}, {26'd0, dig_en}, 32'd1 << k);
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (sec_tick) begin
        n = i;
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; prog = 1'b0; adjust = 1'b0;
    fmt12 = 1'b0; com_anode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dig_en", {26'd0, dig_en}, 32'h01);
    check("rst_seg", {25'd0, seg_out}, 32'h3F);
    check("rst_tick", {31'd0, sec_tick}, 32'd0);
    check("rst_ampm", {31'd0, ampm}, 32'd0);
    check("rst_alarm", {31'd0, alarm}, 32'd0);
    rst_n = 1'b1;

    // Scan order and first second
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      check("scan_dig_en", {26'd0, dig_en}, 32'd1 << (((n - 1) / 2) % 6));
      check("first_tick", {31'd0, sec_tick}, {31'd0, n == 20});
    end
    chk_digit("sec_u_one", 0, c_SEG[1]);

    // Back to a known 00:00:00, then preload 23:59:59
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    press(1'b1, 1'b0);
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    for (int i = 0; i < 23; i++) press(1'b0, 1'b1);
    chk_digit("sethr_t", 5, c_SEG[2]);
    chk_digit("sethr_u", 4, c_SEG[3]);
    chk_digit("sethr_blank_sec", 0, 7'h00);
    chk_digit("sethr_blank_min", 2, 7'h00);
    fmt12 = 1'b1;
    chk_digit("sethr12_u", 4, c_SEG[1]);
    chk_digit("sethr12_t", 5, c_SEG[1]);
    check("sethr12_pm", {31'd0, ampm}, 32'd1);

    press(1'b1, 1'b0);
    wait_tick(40, got);
    check("reentry_tick_delay", got, 32'd17);
    chk_digit("roll_su", 0, c_SEG[0]);
    chk_digit("roll_st", 1, c_SEG[0]);
    chk_digit("roll_mu", 2, c_SEG[0]);
    chk_digit("roll_mt", 3, c_SEG[0]);
    chk_digit("roll_hu12", 4, c_SEG[2]);
    chk_digit("roll_ht12", 5, c_SEG[1]);
    check("roll_am", {31'd0, ampm}, 32'd0);

    // Minute wrap in SET_MIN leaves the hour alone
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
    chk_digit("setmin_mt59", 3, c_SEG[5]);
    chk_digit("setmin_mu59", 2, c_SEG[9]);
    press(1'b0, 1'b1);
    chk_digit("setmin_mu00", 2, c_SEG[0]);
    chk_digit("setmin_mt00", 3, c_SEG[0]);
    com_anode = 1'b1;
    chk_digit("ca_blank0", 0, 7'h7F);
    chk_digit("ca_blank1", 1, 7'h7F);
    chk_digit("ca_min_u", 2, 7'h40);
    chk_digit("ca_blank4", 4, 7'h7F);
    chk_digit("ca_blank5", 5, 7'h7F);
    press(1'b1, 1'b0);
    chk_digit("ca_hr_u", 4, 7'h24);
    chk_digit("ca_hr_t", 5, 7'h79);

    // Asynchronous reset mid-count, asserted while sec_tick is high
    com_anode = 1'b0;
    press(1'b1, 1'b0);
    wait_tick(40, got);
    check("pre_reset_tick_seen", {31'd0, got > 0}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_dig_en", {26'd0, dig_en}, 32'h01);
    check("async_rst_seg", {25'd0, seg_out}, 32'h3F);
    check("async_rst_tick", {31'd0, sec_tick}, 32'd0);
    check("async_rst_ampm", {31'd0, ampm}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // prog and adjust together in SET_SEC: mode advances, adjust dropped
    press(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    chk_digit("both_sec_blank", 0, 7'h00);
    chk_digit("both_min_u", 2, c_SEG[0]);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk_digit("both_sec_u", 0, c_SEG[3]);
    chk_digit("both_sec_t", 1, c_SEG[0]);

`ifdef RTC_ALARM_EN
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk_digit("al_min_u", 2, c_SEG[1]);
    chk_digit("al_blank_sec", 0, 7'h00);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    got = -1;
    for (int i = 1; i <= 1300; i++) begin
      @(negedge clk);
      if (alarm) begin
        got = i;
        break;
      end
    end
    check("alarm_delay", got, 32'd1197);
    check("alarm_at_tick", {31'd0, sec_tick}, 32'd1);
    @(negedge clk); adjust = 1'b1;
    repeat (3) @(negedge clk);
    check("alarm_hold", {31'd0, alarm}, 32'd1);
    @(negedge clk);
    check("alarm_ack", {31'd0, alarm}, 32'd0);
    adjust = 1'b0;
`else
    check("alarm_tied", {31'd0, alarm}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/rtc_7seg_scan.md
# rtc_7seg_scan

Parametrised successor to the team's 10 MHz 7-segment clock. A single-clock-domain HH:MM[:SS] real-time clock with button-driven set modes, 12/24 h formatting and a time-multiplexed 7-segment scan driver. All divided rates are clock enables, with no derived clocks. It sits between the board pins (buttons, switches) and the display, replacing the fixed-width clock/display pair.

## Interface
Parameters:
- `CLK_HZ`, 10_000_000, input clock cycles per second (≥ 4)
- `SCAN_DIV`, 5000, clock cycles each digit stays lit (≥ 1)
- `NUM_DIGITS`, 6, 6 = HH:MM:SS, 4 = HH:MM; other values illegal

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset; one clock, reset is asynchronous active-low
- `ena`  in  1  when low, second prescaler and scan counter hold
- `prog`  in  1  raw mode button, active-high, asynchronous
- `adjust`  in  1  raw adjust button, active-high, asynchronous
- `fmt12`  in  1  1 = 12 h display, 0 = 24 h
- `com_anode`  in  1  1 = segments active-low, 0 = active-high
- `seg_out`  out  7  segments a..g, bit0 = a
- `dig_en`  out  NUM_DIGITS  one-hot digit enable, active-high, bit0 = rightmost digit
- `ampm`  out  1  1 = PM (only when fmt12 = 1, else 0)
- `sec_tick`  out  1  one-cycle pulse per elapsed second in RUN
- `alarm`  out  1  alarm active (0 if ALARM_EN undefined)

## Operation
- `prog` and `adjust` each pass through a 2-FF synchroniser followed by a rising-edge detector. This produces one-cycle `prog_p` / `adj_p` pulses.
- Time registers are BCD: sec_u 0-9, sec_t 0-5, min_u 0-9, min_t 0-5, hr 0-23 (binary, 5 bits).
- Mode FSM advances one state on each `prog_p`:
  - RUN → SET_SEC → SET_MIN → SET_HR → RUN.
  - With NUM_DIGITS = 4, SET_SEC is skipped.
  - With ALARM_EN, SET_HR → AL_MIN → AL_HR → RUN.
- RUN:
  - Prescaler counts 0..CLK_HZ-1 while `ena` = 1.
  - At the terminal count it wraps, pulses `sec_tick`, and increments seconds with full carry chain: 59 s → 0 with minute +1, 59 min → 0 with hour +1, 23:59:59 → 00:00:00.
  - `adj_p` is ignored in RUN, except for alarm acknowledge.
- SET_* modes:
  - Time is frozen and the prescaler is held at 0.
  - `adj_p` increments only the selected field with wrap and no carry: sec 59 → 00, min 59 → 00, hr 23 → 00.
- Display:
  - Digit order from bit0 is sec_u, sec_t, min_u, min_t, hr_u, hr_t; 4-digit builds drop the seconds digits.
  - 12 h mapping: hr 0 → 12 AM, 1-11 → AM, 12 → 12 PM, 13-23 → hr-12 PM.
  - In set/alarm modes, digits of non-selected fields are blanked (all segments off). Alarm modes show the alarm HH:MM in place of the time.
- Segment encoding is active-high a..g: 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F, blank = 00. When `com_anode` = 1 the encoding is inverted.
- Scan:
  - A counter 0..SCAN_DIV-1 advances while `ena` = 1.
  - At terminal count the digit index advances 0..NUM_DIGITS-1, then wraps to 0.

## Timing
- Reset values:
  - All time registers 0; mode RUN; prescaler 0; scan index 0.
  - `dig_en` = 1 (digit 0); `seg_out` = encoding of 0 per `com_anode`.
  - `sec_tick` = 0; `ampm` = 0 (in 12 h mode, hour 0 is AM); `alarm` = 0.
- Button latency: input rise → `prog_p`/`adj_p` 3 cycles later → register update visible on the following cycle.
- The first `sec_tick` after reset or after re-entering RUN occurs CLK_HZ cycles later.
- `seg_out`, `dig_en` and `ampm` are registered: one cycle after the scan index or time changes.
- Simultaneous events:
  - `prog_p` on the same cycle as a prescaler terminal count: the second is counted first, then the mode changes.
  - `prog_p` and `adj_p` together: the mode changes and the adjust is dropped.
- `rst_n` assertion mid-operation clears everything asynchronously. Synchroniser flops also reset to 0, so a button held through reset produces no pulse.

## Configuration
- `RTC_ALARM_EN` defined:
  - Adds alarm registers (min 0-59, hr 0-23, reset 00:00) and the AL_MIN/AL_HR modes.
  - `alarm` is set in RUN when the time reaches alarm HH:MM:00 (HH:MM at a minute rollover for 4-digit builds).
  - `alarm` clears on `adj_p`, on leaving RUN, or after 60 s.
- `RTC_ALARM_EN` undefined: no alarm logic, `alarm` tied 0, mode FSM has 4 states (3 when NUM_DIGITS = 4).

## Test plan
- Bench setup: CLK_HZ = 20, SCAN_DIV = 2, NUM_DIGITS = 6.
- Reset then 20 cycles → `sec_tick` pulses once, sec_u = 1; `dig_en` cycles 01, 02, 04…20 every 2 cycles.
- Preload 23:59:59 via set modes, return to RUN, wait 20 cycles → 00:00:00; with `fmt12` = 1 the hour digits show 1 and 2 (12), `ampm` = 0.
- SET_MIN at 59, one `adjust` pulse → min 00 and hour unchanged; digits 0, 1, 4, 5 read blank (00 / 7F per `com_anode`).
- `prog` and `adjust` rising on the same cycle in SET_SEC → mode SET_MIN, seconds unchanged; `rst_n` low mid-count → all outputs at reset values immediately.
- RTC_ALARM_EN: alarm 00:01, run from 00:00:00 for 60 s → `alarm` = 1 at 00:01:00; `adjust` → `alarm` = 0 after 4 cycles.
